// File: rtl/button_event_scheduler.sv
// Shared-tick debounce scanner for N slow inputs, queueing level-change events in a FWFT FIFO.
// Optional macro BTN_RELEASE_EVT_EN: also queue release events (default build queues presses only).
module button_event_scheduler #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 1500,
  parameter int STABLE_TICKS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [N-1:0]                         btn_in,
  input  logic                                 evt_ready,
  input  logic                                 clr_overflow,
  output logic                                 evt_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] evt_chan,
  output logic                                 evt_press,
  output logic [N-1:0]                         level,
  output logic                                 overflow
);

  localparam int CHW  = (N > 1) ? $clog2(N) : 1;
  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNTW = $clog2(STABLE_TICKS + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [N-1:0]    sync1_reg, sync2_reg;
  logic [DIVW-1:0] div_reg, div_next;
  logic            tick;
  state_t          state_reg, state_next;
  logic [CHW-1:0]  idx_reg, idx_next;
  logic            scanning;
  logic [N-1:0]    level_reg;
  logic [N-1:0]    toggle;
  logic            push, pop, full, do_push, drop;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            overflow_reg;
  logic [CHW-1:0]  mem_chan [FIFO_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign tick     = (div_reg == DIVW'(TICK_DIV - 1));
  assign div_next = tick ? '0 : div_reg + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg   <= '0;
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      div_reg   <= div_next;
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // One channel per clock while scanning; the divider period guarantees the scan ends before the next tick.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (tick) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        if (idx_reg == CHW'(N - 1)) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign scanning = (state_reg == SCAN);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic            sel, differ;
    logic            lvl_reg;
    logic [CNTW-1:0] cnt_reg;

    assign sel           = scanning && (idx_reg == CHW'(gi));
    assign differ        = sync2_reg[gi] ^ lvl_reg;
    assign toggle[gi]    = sel && differ && (cnt_reg == CNTW'(STABLE_TICKS - 1));
    assign level_reg[gi] = lvl_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lvl_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (sel) begin
        if (!differ) begin
          cnt_reg <= '0;
        end else if (toggle[gi]) begin
          lvl_reg <= ~lvl_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  logic push_level;
  logic mem_press [FIFO_DEPTH];

  assign push       = |toggle;
  assign push_level = |(toggle & ~level_reg);

  always_ff @(posedge clk) begin
    if (do_push) mem_press[wr_ptr_reg] <= push_level;
  end

  assign evt_press = evt_valid ? mem_press[rd_ptr_reg] : 1'b0;
`else
  // Only a 0->1 toggle pushes; releases still move the level but never touch the queue.
  assign push      = |(toggle & ~level_reg);
  assign evt_press = 1'b1;
`endif

  assign evt_valid = (count_reg != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign count_next = count_reg + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (do_push) mem_chan[wr_ptr_reg] <= idx_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop)              overflow_reg <= 1'b1;
      else if (clr_overflow) overflow_reg <= 1'b0;
    end
  end

  // Head fields read as zero while empty so stale memory never reaches the outputs.
  assign evt_chan = evt_valid ? mem_chan[rd_ptr_reg] : '0;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler (N=4, TICK_DIV=16, STABLE_TICKS=3, FIFO_DEPTH=4).
module tb_button_event_scheduler;

`ifdef BTN_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] btn_in;
  logic       evt_ready;
  logic       clr_overflow;
  logic       evt_valid;
  logic [1:0] evt_chan;
  logic       evt_press;
  logic [3:0] level;
  logic       overflow;

  typedef struct {
    int chan;
    int press;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc;
  int  pass_cnt;
  int  total_cnt;

  button_event_scheduler #(
    .N(4), .TICK_DIV(16), .STABLE_TICKS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_chan(evt_chan),
    .evt_press(evt_press), .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; equals the current cycle when read between edges.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always begin
    @(negedge clk);
    #2;
    if (reset_n && evt_valid && evt_ready) begin
      q.push_back('{chan: int'(evt_chan), press: int'(evt_press), cyc: cyc});
      $display("event chan=%0d press=%0d cycle=%0d", evt_chan, evt_press, cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step(1);
  endtask

  // Processing cycle of the accepting (3rd) sample for a change driven in cycle c on channel k.
  function automatic int accept_cyc(input int c, input int k);
    int p;
    p = 16 + k;
    while (p < c + 2) p += 16;
    return p + 32;
  endfunction

  initial begin
    int c, t, t0, t1;
    pass_cnt     = 0;
    total_cnt    = 0;
    reset_n      = 1'b0;
    btn_in       = 4'b0000;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;

    step(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_chan", evt_chan, 0);
    chk("rst_press", evt_press, REL ? 0 : 1);

    // Clean press on channel 2, released together with reset in cycle 0
    step(1);
    reset_n = 1'b1;
    btn_in  = 4'b0100;
    t = accept_cyc(0, 2);
    wait_until(t - 16);
    chk("press_level_2ticks", level, 4'b0000);
    wait_until(t);
    chk("press_level_before", level, 4'b0000);
    chk("press_valid_before", evt_valid, 0);
    wait_until(t + 1);
    chk("press_level_after", level, 4'b0100);
    chk("press_valid", evt_valid, 1);
    chk("press_chan", evt_chan, 2);
    chk("press_press", evt_press, 1);
    wait_until(t + 2);
    chk("press_valid_1cyc", evt_valid, 0);
    wait_until(t + 10);
    chk("press_count", q.size(), 1);
    q.delete();

    // Bounce on channel 1: toggles once per tick period
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = ~btn_in[1];
      step(16);
    end
    step(80);
    chk("bounce_level", level, 4'b0100);
    chk("bounce_events", q.size(), 0);

    // Simultaneous press on channels 0 and 3
    c = cyc;
    btn_in = 4'b1101;
    t0 = accept_cyc(c, 0);
    t1 = accept_cyc(c, 3);
    wait_until(t1 + 5);
    chk("simul_count", q.size(), 2);
    chk("simul_chan0", q[0].chan, 0);
    chk("simul_press0", q[0].press, 1);
    chk("simul_cyc0", q[0].cyc, t0 + 1);
    chk("simul_chan1", q[1].chan, 3);
    chk("simul_press1", q[1].press, 1);
    chk("simul_gap", q[1].cyc - q[0].cyc, 3);
    chk("simul_level", level, 4'b1101);
    q.delete();

    btn_in = 4'b0000;
    step(60);
    chk("relall_level", level, 4'b0000);
    chk("relall_events", q.size(), REL ? 3 : 0);
    q.delete();

    // Overflow: fill the queue with ready low, then attempt more events
    evt_ready = 1'b0;
    btn_in    = 4'b1111;
    step(60);
    chk("full_valid", evt_valid, 1);
    chk("full_chan", evt_chan, 0);
    chk("full_no_overflow", overflow, 0);
    btn_in = 4'b1110;
    step(60);
    chk("rel_drop_overflow", overflow, REL ? 1 : 0);
    chk("rel_drop_level", level, 4'b1110);
    chk("held_chan", evt_chan, 0);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("clr1_overflow", overflow, 0);

    c = cyc;
    btn_in = 4'b1111;
    t = accept_cyc(c, 0);
    wait_until(t);
    chk("drop_pre_overflow", overflow, 0);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("drop_set_wins", overflow, 1);
    chk("drop_level", level, 4'b1111);
    step(3);
    chk("held_valid", evt_valid, 1);
    chk("held_chan2", evt_chan, 0);
    chk("held_press", evt_press, 1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("clr2_overflow", overflow, 0);

    evt_ready = 1'b1;
    step(10);
    chk("drain_count", q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_chan", q[i].chan, i);
      chk("drain_press", q[i].press, 1);
    end
    chk("drain_empty", evt_valid, 0);
    q.delete();

    // Release filtering on channel 0
    btn_in = 4'b0000;
    step(60);
    q.delete();
    btn_in = 4'b0001;
    step(60);
    btn_in = 4'b0000;
    step(60);
    chk("relf_level", level, 4'b0000);
    chk("relf_count", q.size(), REL ? 2 : 1);
    chk("relf_chan0", q[0].chan, 0);
    chk("relf_press0", q[0].press, 1);
    if (q.size() > 1) begin
      chk("relf_chan1", q[1].chan, 0);
      chk("relf_press1", q[1].press, 0);
    end
    q.delete();

    // Reset mid-scan with two events queued
    evt_ready = 1'b0;
    c = cyc;
    btn_in = 4'b0011;
    t0 = accept_cyc(c, 0);
    t1 = accept_cyc(c, 1);
    wait_until(((t0 > t1) ? t0 : t1) + 1);
    chk("mid_valid", evt_valid, 1);
    chk("mid_level", level, 4'b0011);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_chan", evt_chan, 0);
    step(2);
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    q.delete();
    t = accept_cyc(0, 0);
    wait_until(t);
    chk("post_rst_valid", evt_valid, 0);
    chk("post_rst_level", level, 0);
    wait_until(t + 1);
    chk("post_rst_chan0", evt_chan, 0);
    chk("post_rst_level0", level, 4'b0001);
    wait_until(t + 2);
    chk("post_rst_chan1", evt_chan, 1);
    chk("post_rst_level1", level, 4'b0011);
    step(10);
    chk("post_rst_count", q.size(), 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
